// File: rtl/wb_dma_master_pkg.sv
// Shared types for the Wishbone DMA initiator.
// State encoding and bus select constant.
package wb_dma_master_pkg;

  typedef enum logic [1:0] {
    WBDMA_IDLE,
    WBDMA_ISSUE,
    WBDMA_DRAIN,
    WBDMA_DONE
  } wbdma_state_t;

  localparam logic [3:0] WB_SEL_WORD = 4'hF;

endpackage

// File: rtl/wb_dma_master_fifo.sv
// First-word-fall-through FIFO holding read data
// until the stream consumer pops it.
module wb_dma_fifo #(
  parameter int width    = 32,
  parameter int adr_bits = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [width-1:0]    wdata,
  input  logic                pop,
  output logic [width-1:0]    rdata,
  output logic                valid,
  output logic [adr_bits:0]   count
);

  localparam int CW = adr_bits + 1;

  logic [width-1:0]    mem [2**adr_bits];
  logic [adr_bits-1:0] wr_ptr;
  logic [adr_bits-1:0] rd_ptr;
  logic                do_pop;

  assign valid  = count != '0;
  assign do_pop = pop & valid;
  assign rdata  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/wb_dma_master.sv
// Pipelined Wishbone initiator moving word blocks
// between a stream port and the core's DMA slave.
module wb_dma_master
  import wb_dma_master_pkg::*;
#(
  parameter int len_bits        = 16,
  parameter int max_outstanding = 4,
  parameter int fifo_adr_bits   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [31:0]         cmd_adr,
  input  logic [len_bits-1:0] cmd_len,
  input  logic [31:0]         src_data,
  input  logic                src_valid,
  output logic                src_ready,
  output logic [31:0]         dst_data,
  output logic                dst_valid,
  input  logic                dst_ready,
  output logic                busy,
  output logic                done,
  output logic [31:0]         wb_out,
  input  logic [31:0]         wb_in,
  output logic [31:0]         wb_adr,
  output logic [3:0]          wb_sel,
  output logic                wb_cyc,
  output logic                wb_stb,
  output logic                wb_we,
  input  logic                wb_ack,
  input  logic                wb_stall
);

  localparam int CW = fifo_adr_bits + 1;
  localparam logic [CW-1:0] MAX_OUT = CW'(max_outstanding);

  wbdma_state_t        state;
  wbdma_state_t        state_next;
  logic [len_bits-1:0] issue_cnt;
  logic [CW-1:0]       out_cnt;
  logic [CW-1:0]       out_next;
  logic [CW-1:0]       fifo_count;
  logic [CW-1:0]       fifo_next;
  logic [CW:0]         rd_sum;
  logic                hs;
  logic                accept;
  logic                ack_eff;
  logic                push;
  logic                pop;
  logic                room;
  logic                load;

  assign hs      = cmd_valid & cmd_ready;
  assign accept  = wb_stb & ~wb_stall;
  assign ack_eff = wb_ack & (out_cnt != '0);
  assign push    = ack_eff & ~wb_we;
  assign pop     = dst_valid & dst_ready;

  assign out_next  = out_cnt + CW'(accept) - CW'(ack_eff);
  assign fifo_next = fifo_count + CW'(push) - CW'(pop);
  assign rd_sum    = {1'b0, fifo_next} + {1'b0, out_next};

  // Read credit counts both queued data and requests still in flight
  assign room = (out_next < MAX_OUT) &&
                (wb_we ? src_valid : (rd_sum < {1'b0, MAX_OUT}));

  assign load = (state == WBDMA_ISSUE) &&
                (!wb_stb || accept) &&
                ((issue_cnt - len_bits'(accept)) != '0) &&
                room;

  assign cmd_ready = state == WBDMA_IDLE;
  assign busy      = state != WBDMA_IDLE;
  assign done      = state == WBDMA_DONE;
  assign src_ready = load & wb_we;
  assign wb_sel    = wb_stb ? WB_SEL_WORD : 4'h0;

  always_comb begin
    state_next = state;
    unique case (state)
      WBDMA_IDLE: begin
        // Empty commands drain an empty pipe: no bus cycle, same done timing
        if (hs)
          state_next = (cmd_len == '0) ? WBDMA_DRAIN : WBDMA_ISSUE;
      end
      WBDMA_ISSUE: begin
        if (accept && issue_cnt == len_bits'(1))
          state_next = WBDMA_DRAIN;
      end
      WBDMA_DRAIN: begin
        if (out_next == '0) state_next = WBDMA_DONE;
      end
      WBDMA_DONE: state_next = WBDMA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= WBDMA_IDLE;
      issue_cnt <= '0;
      out_cnt   <= '0;
      wb_adr    <= '0;
      wb_out    <= '0;
      wb_we     <= 1'b0;
      wb_cyc    <= 1'b0;
      wb_stb    <= 1'b0;
    end else begin
      state   <= state_next;
      out_cnt <= out_next;
      wb_cyc  <= (state_next == WBDMA_ISSUE) ||
                 (state_next == WBDMA_DRAIN && out_next != '0);
      if (hs) begin
        wb_adr    <= cmd_adr & ~32'h3;
        issue_cnt <= cmd_len;
        wb_we     <= cmd_we;
      end else if (accept) begin
        wb_adr    <= wb_adr + 32'd4;
        issue_cnt <= issue_cnt - 1'b1;
      end
      if (load) begin
        wb_stb <= 1'b1;
        if (wb_we) wb_out <= src_data;
      end else if (accept) begin
        wb_stb <= 1'b0;
      end
    end
  end

  wb_dma_fifo #(
    .width    (32),
    .adr_bits (fifo_adr_bits)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wb_in),
    .pop   (pop),
    .rdata (dst_data),
    .valid (dst_valid),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_wb_dma_master.sv
// Directed bench for wb_dma_master with a
// pipelined Wishbone slave model.
module tb_wb_dma_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [15:0] cmd_len;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic [31:0] dst_data;
  logic        dst_valid;
  logic        dst_ready;
  logic        busy;
  logic        done;
  logic [31:0] wb_out;
  logic [31:0] wb_in;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic        wb_ack;
  logic        wb_stall;

  wb_dma_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_len(cmd_len),
    .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready),
    .dst_data(dst_data), .dst_valid(dst_valid),
    .dst_ready(dst_ready),
    .busy(busy), .done(done),
    .wb_out(wb_out), .wb_in(wb_in),
    .wb_adr(wb_adr), .wb_sel(wb_sel),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb),
    .wb_we(wb_we), .wb_ack(wb_ack),
    .wb_stall(wb_stall)
  );

  typedef struct {
    int          due;
    logic [31:0] adr;
  } pend_t;

  pend_t       pq[$];
  int          n_chk;
  int          n_pass;
  int          cyc_no;
  int          hs_cyc;
  int          ack_delay;
  int          n_acc;
  int          n_dst;
  int          n_done;
  int          nd0;
  int          done_cyc;
  int          last_ack_cyc;
  int          src_idx;
  int          outst;
  int          max_out;
  int          cyc_seen;
  int          sel_bad;
  int          stall_idx;
  int          stall_len;
  int          stall_left;
  int          stall_seen;
  int          stall_bad;
  bit          stall_armed;
  logic        ready_at_done;
  logic [31:0] stall_adr;
  logic [31:0] stall_dat;
  logic [31:0] acc_adr [64];
  logic [31:0] acc_dat [64];
  int          acc_cyc [64];
  logic [31:0] dst_rec [64];
  logic [31:0] src_words [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 16; i++)
      src_words[i] = base + 32'(i);
  endtask

  task automatic clear_rec();
    n_acc       = 0;
    n_dst       = 0;
    src_idx     = 0;
    max_out     = 0;
    cyc_seen    = 0;
    stall_seen  = 0;
    stall_bad   = 0;
    stall_armed = 0;
    nd0         = n_done;
  endtask

  task automatic issue(input logic we,
                       input logic [31:0] adr,
                       input int len);
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_len   = 16'(len);
    cmd_valid = 1'b1;
    hs_cyc    = cyc_no;
    check("hs_ready", cmd_ready, 1);
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget,
                           input string tag);
    int i;
    i = 0;
    while (n_done == nd0 && i < budget) begin
      step(1);
      i++;
    end
    check(tag, 32'(n_done == nd0), 0);
  endtask

  // Slave: fixed ack latency, optional stall on one request
  initial forever begin
    @(posedge clk);
    cyc_no++;
    #1;
    wb_ack = 1'b0;
    if (pq.size() > 0 && pq[0].due == cyc_no) begin
      wb_ack = 1'b1;
      wb_in  = pq[0].adr;
      void'(pq.pop_front());
    end
    if (stall_armed && wb_stb && n_acc == stall_idx) begin
      stall_left  = stall_len;
      stall_armed = 0;
    end
    wb_stall = stall_left > 0;
    if (stall_left > 0) stall_left--;
    src_data = src_words[src_idx < 16 ? src_idx : 15];
  end

  initial forever begin
    @(negedge clk);
    if (wb_cyc) cyc_seen++;
    if (wb_stb && !wb_stall) begin
      if (n_acc < 64) begin
        acc_adr[n_acc] = wb_adr;
        acc_dat[n_acc] = wb_out;
        acc_cyc[n_acc] = cyc_no;
      end
      n_acc++;
      pq.push_back('{due: cyc_no + ack_delay, adr: wb_adr});
      outst++;
    end
    if (wb_ack) begin
      outst--;
      last_ack_cyc = cyc_no;
    end
    if (outst > max_out) max_out = outst;
    if (wb_stb && wb_stall) begin
      if (stall_seen == 0) begin
        stall_adr = wb_adr;
        stall_dat = wb_out;
      end else if (wb_adr != stall_adr || wb_out != stall_dat) begin
        stall_bad++;
      end
      if (src_ready) stall_bad++;
      stall_seen++;
    end
    if (src_ready) src_idx++;
    if (dst_valid && dst_ready) begin
      if (n_dst < 64) dst_rec[n_dst] = dst_data;
      n_dst++;
    end
    if (done) begin
      n_done++;
      done_cyc      = cyc_no;
      ready_at_done = cmd_ready;
    end
    if (wb_sel !== (wb_stb ? 4'hF : 4'h0)) sel_bad++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; cyc_no = 0; n_done = 0;
    outst = 0; sel_bad = 0; stall_left = 0;
    stall_idx = 0; stall_len = 0; ack_delay = 1;
    rst = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0;
    cmd_adr = '0; cmd_len = '0; src_valid = 1'b0;
    dst_ready = 1'b0; wb_ack = 1'b0; wb_stall = 1'b0;
    wb_in = '0; src_data = '0;
    fill(32'h0);
    clear_rec();

    step(3);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_cyc", wb_cyc, 0);
    check("rst_stb", wb_stb, 0);
    check("rst_dst_valid", dst_valid, 0);
    check("rst_done", done, 0);
    check("rst_adr", wb_adr, 0);
    check("rst_sel", wb_sel, 0);
    rst = 1'b1;
    step(2);

    // Write burst, no stall
    clear_rec();
    fill(32'hA000_0000);
    src_valid = 1'b1;
    ack_delay = 1;
    issue(1'b1, 32'h100, 4);
    wait_done(100, "t1_timeout");
    step(3);
    check("t1_n_acc", n_acc, 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_adr", acc_adr[i], 32'h100 + 32'(4 * i));
      check("t1_dat", acc_dat[i], 32'hA000_0000 + 32'(i));
      check("t1_cyc", acc_cyc[i] - hs_cyc, 2 + i);
    end
    check("t1_done_lat", done_cyc - last_ack_cyc, 1);
    check("t1_done_cnt", n_done - nd0, 1);
    check("t1_src_cnt", src_idx, 4);
    check("t1_no_dst", n_dst, 0);

    // Read with consumer blocked, then drain
    clear_rec();
    src_valid = 1'b0;
    dst_ready = 1'b0;
    issue(1'b0, 32'h200, 8);
    step(12);
    check("t2_n_acc_blk", n_acc, 4);
    check("t2_stb_idle", wb_stb, 0);
    check("t2_dst_valid", dst_valid, 1);
    check("t2_head", dst_data, 32'h200);
    dst_ready = 1'b1;
    wait_done(200, "t2_timeout");
    step(8);
    check("t2_n_acc", n_acc, 8);
    check("t2_n_dst", n_dst, 8);
    for (int i = 0; i < 8; i++)
      check("t2_data", dst_rec[i], 32'h200 + 32'(4 * i));
    check("t2_empty", dst_valid, 0);

    // Write with a 5-cycle stall on the second request
    clear_rec();
    dst_ready = 1'b0;
    fill(32'hB000_0000);
    src_valid   = 1'b1;
    stall_idx   = 1;
    stall_len   = 5;
    stall_armed = 1;
    issue(1'b1, 32'h0, 3);
    wait_done(100, "t3_timeout");
    step(3);
    check("t3_n_acc", n_acc, 3);
    for (int i = 0; i < 3; i++) begin
      check("t3_adr", acc_adr[i], 32'(4 * i));
      check("t3_dat", acc_dat[i], 32'hB000_0000 + 32'(i));
    end
    check("t3_stall_cycles", stall_seen, 5);
    check("t3_stall_adr", stall_adr, 32'h4);
    check("t3_stall_dat", stall_dat, 32'hB000_0001);
    check("t3_stall_hold", stall_bad, 0);
    check("t3_src_cnt", src_idx, 3);

    // Zero-length command
    clear_rec();
    src_valid = 1'b0;
    issue(1'b1, 32'h80, 0);
    wait_done(20, "t4_timeout");
    check("t4_done_lat", done_cyc - hs_cyc, 2);
    check("t4_ready_at_done", ready_at_done, 0);
    check("t4_ready_after", cmd_ready, 1);
    check("t4_no_cyc", cyc_seen, 0);
    check("t4_no_acc", n_acc, 0);

    // Reset in the middle of a read
    clear_rec();
    dst_ready = 1'b0;
    ack_delay = 2;
    issue(1'b0, 32'h300, 8);
    step(4);
    check("t5_pre_valid", dst_valid, 1);
    check("t5_pre_outst", outst, 2);
    #1;
    rst    = 1'b0;
    wb_ack = 1'b0;
    pq.delete();
    outst  = 0;
    #1;
    check("t5_cyc_drop", wb_cyc, 0);
    check("t5_stb_drop", wb_stb, 0);
    check("t5_fifo_empty", dst_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_cmd_ready", cmd_ready, 1);
    step(2);
    rst = 1'b1;
    step(2);
    clear_rec();
    ack_delay = 1;
    dst_ready = 1'b1;
    issue(1'b0, 32'h400, 2);
    wait_done(100, "t5_timeout");
    step(4);
    check("t5_n_acc", n_acc, 2);
    check("t5_n_dst", n_dst, 2);
    check("t5_data0", dst_rec[0], 32'h400);
    check("t5_data1", dst_rec[1], 32'h404);

    // Accept and ack together at max_outstanding-1
    clear_rec();
    dst_ready = 1'b0;
    fill(32'hC000_0000);
    src_valid = 1'b1;
    ack_delay = 3;
    issue(1'b1, 32'h40, 6);
    wait_done(100, "t6_timeout");
    step(3);
    check("t6_n_acc", n_acc, 6);
    check("t6_first", acc_cyc[0] - hs_cyc, 2);
    check("t6_no_bubble", acc_cyc[5] - acc_cyc[0], 5);
    check("t6_max_out", max_out, 3);
    check("t6_last_adr", acc_adr[5], 32'h54);
    check("t6_last_dat", acc_dat[5], 32'hC000_0005);
    check("t6_done_cnt", n_done - nd0, 1);

    check("sel_tracks_stb", sel_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
